// File: rtl/core_pkg.sv
// Shared core types: operand source-pair encodings for the execute stage.
package core_pkg;

    typedef enum logic [2:0] {
        SRC_RR = 3'd0,
        SRC_RI = 3'd1,
        SRC_PI = 3'd2,
        SRC_ZI = 3'd3,
        SRC_MR = 3'd4,
        SRC_CA = 3'd5,
        SRC_CI = 3'd6
    } exec_src_e;

endpackage

// File: rtl/core_exec_operand_stage_if.sv
// Operand request (decode/regfile side) and operand result (ALU side) handshakes.
interface core_exec_operand_stage_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    import core_pkg::*;

    logic               in_valid;
    logic               in_ready;
    exec_src_e          exec_src;
    logic [RADDR_W-1:0] rs_a_addr;
    logic [RADDR_W-1:0] rs_b_addr;
    logic [XLEN-1:0]    reg_a_value;
    logic [XLEN-1:0]    reg_b_value;
    logic [XLEN-1:0]    imm_val;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    csr_rdata;

    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    src_a;
    logic [XLEN-1:0]    src_b;
    logic               illegal_src;

    modport slave (
        input  in_valid, exec_src, rs_a_addr, rs_b_addr, reg_a_value, reg_b_value,
               imm_val, pc, csr_rdata, out_ready,
        output in_ready, out_valid, src_a, src_b, illegal_src
    );

    modport master (
        output in_valid, exec_src, rs_a_addr, rs_b_addr, reg_a_value, reg_b_value,
               imm_val, pc, csr_rdata, out_ready,
        input  in_ready, out_valid, src_a, src_b, illegal_src
    );

endinterface

// File: rtl/core_exec_operand_stage.sv
// Execute-stage operand selector with forwarding, AMO memory-datum hold and a
// 2-entry (main + skid) output buffer.
//
// state    | meaning
// ST_EMPTY | no entry buffered
// ST_ONE   | main holds the presented entry
// ST_TWO   | main presented, skid holds the next entry; upstream stalled
module core_exec_operand_stage
    import core_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int RADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    core_exec_operand_stage_if.slave   bus,
    input  logic                       mem_rvalid,
    input  logic [XLEN-1:0]            mem_rdata,
    input  logic [NUM_FWD-1:0]         fwd_valid,
    input  logic [NUM_FWD*RADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]    fwd_data
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] main_a_q, main_a_d, main_b_q, main_b_d;
    logic [XLEN-1:0] skid_a_q, skid_a_d, skid_b_q, skid_b_d;
    logic            main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;
    logic            in_ready_q;
    logic [XLEN-1:0] mem_last_q;

    logic [XLEN-1:0] eff_a, eff_b, eff_mem;
    logic [XLEN-1:0] sel_a, sel_b;
    logic            sel_ill;
    logic            accept, pop;

    // Walk from the lowest-priority port up so port 0 overwrites last and wins.
    always_comb begin
        eff_a = bus.reg_a_value;
        eff_b = bus.reg_b_value;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (bus.rs_a_addr != '0) &&
                (fwd_addr[i*RADDR_W +: RADDR_W] == bus.rs_a_addr))
                eff_a = fwd_data[i*XLEN +: XLEN];
            if (fwd_valid[i] && (bus.rs_b_addr != '0) &&
                (fwd_addr[i*RADDR_W +: RADDR_W] == bus.rs_b_addr))
                eff_b = fwd_data[i*XLEN +: XLEN];
        end
    end

    assign eff_mem = mem_rvalid ? mem_rdata : mem_last_q;

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_ill = 1'b0;
        case (bus.exec_src)
            SRC_RR:  begin sel_a = eff_a;         sel_b = eff_b;       end
            SRC_RI:  begin sel_a = eff_a;         sel_b = bus.imm_val; end
            SRC_PI:  begin sel_a = bus.pc;        sel_b = bus.imm_val; end
            SRC_ZI:  begin sel_a = '0;            sel_b = bus.imm_val; end
            SRC_MR:  begin sel_a = eff_mem;       sel_b = eff_b;       end
            SRC_CA:  begin sel_a = bus.csr_rdata; sel_b = eff_a;       end
            SRC_CI:  begin sel_a = bus.csr_rdata; sel_b = bus.imm_val; end
            default: sel_ill = 1'b1;
        endcase
    end

    assign accept = bus.in_valid && in_ready_q;
    assign pop    = (state_q != ST_EMPTY) && bus.out_ready;

    always_comb begin
        state_d    = state_q;
        main_a_d   = main_a_q;
        main_b_d   = main_b_q;
        main_ill_d = main_ill_q;
        skid_a_d   = skid_a_q;
        skid_b_d   = skid_b_q;
        skid_ill_d = skid_ill_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d    = ST_ONE;
                        main_a_d   = sel_a;
                        main_b_d   = sel_b;
                        main_ill_d = sel_ill;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_a_d   = sel_a;
                        main_b_d   = sel_b;
                        main_ill_d = sel_ill;
                    end else if (accept) begin
                        state_d    = ST_TWO;
                        skid_a_d   = sel_a;
                        skid_b_d   = sel_b;
                        skid_ill_d = sel_ill;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_d    = ST_ONE;
                        main_a_d   = skid_a_q;
                        main_b_d   = skid_b_q;
                        main_ill_d = skid_ill_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_a_q   <= '0;
            main_b_q   <= '0;
            main_ill_q <= 1'b0;
            skid_a_q   <= '0;
            skid_b_q   <= '0;
            skid_ill_q <= 1'b0;
            in_ready_q <= 1'b1;
            mem_last_q <= '0;
        end else begin
            state_q    <= state_d;
            main_a_q   <= main_a_d;
            main_b_q   <= main_b_d;
            main_ill_q <= main_ill_d;
            skid_a_q   <= skid_a_d;
            skid_b_q   <= skid_b_d;
            skid_ill_q <= skid_ill_d;
            // Registered so in_ready never depends combinationally on out_ready.
            in_ready_q <= (state_d != ST_TWO);
            if (mem_rvalid)
                mem_last_q <= mem_rdata;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = (state_q != ST_EMPTY);
    assign bus.src_a       = main_a_q;
    assign bus.src_b       = main_b_q;
    assign bus.illegal_src = main_ill_q;

endmodule

// File: tb/tb_core_exec_operand_stage.sv
// Directed bench for core_exec_operand_stage with hand-computed expectations.
module tb_core_exec_operand_stage;
    import core_pkg::*;

    localparam int XLEN    = 32;
    localparam int NUM_FWD = 2;
    localparam int RADDR_W = 5;

    logic                       clk;
    logic                       rst;
    logic                       flush;
    logic                       mem_rvalid;
    logic [XLEN-1:0]            mem_rdata;
    logic [NUM_FWD-1:0]         fwd_valid;
    logic [NUM_FWD*RADDR_W-1:0] fwd_addr;
    logic [NUM_FWD*XLEN-1:0]    fwd_data;

    int n_chk;
    int n_err;

    core_exec_operand_stage_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();

    core_exec_operand_stage #(
        .XLEN(XLEN), .NUM_FWD(NUM_FWD), .RADDR_W(RADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        flush = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        fwd_valid = '0;
        fwd_addr = '0;
        fwd_data = '0;
        bus.in_valid = 1'b0;
        bus.exec_src = SRC_RR;
        bus.rs_a_addr = '0;
        bus.rs_b_addr = '0;
        bus.reg_a_value = '0;
        bus.reg_b_value = '0;
        bus.imm_val = '0;
        bus.pc = '0;
        bus.csr_rdata = '0;
        bus.out_ready = 1'b0;

        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_src_a", bus.src_a, 0);
        check("rst_src_b", bus.src_b, 0);
        check("rst_illegal", bus.illegal_src, 0);
        @(negedge clk);
        rst = 1'b0;

        // PC + immediate, one-cycle latency
        bus.in_valid = 1'b1; bus.exec_src = SRC_PI;
        bus.pc = 32'h8000_0010; bus.imm_val = 32'h20; bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("pi_out_valid", bus.out_valid, 1);
        check("pi_src_a", bus.src_a, 32'h8000_0010);
        check("pi_src_b", bus.src_b, 32'h20);
        check("pi_in_ready", bus.in_ready, 1);
        step();
        check("pi_drained", bus.out_valid, 0);

        // Forwarding priority: both ports hit x5, port 0 wins
        bus.in_valid = 1'b1; bus.exec_src = SRC_RR;
        bus.rs_a_addr = 5'd5; bus.reg_a_value = 32'h11;
        bus.rs_b_addr = 5'd0; bus.reg_b_value = 32'h22;
        fwd_valid = 2'b11; fwd_addr = {5'd5, 5'd5}; fwd_data = {32'hBB, 32'hAA};
        step();
        check("fwd_prio_a", bus.src_a, 32'hAA);
        check("fwd_b_x0", bus.src_b, 32'h22);
        bus.rs_a_addr = 5'd0;
        step();
        check("fwd_x0_a", bus.src_a, 32'h11);
        bus.rs_a_addr = 5'd5; fwd_valid = 2'b10;
        step();
        check("fwd_port1_a", bus.src_a, 32'hBB);
        bus.in_valid = 1'b0; fwd_valid = 2'b00;
        step();
        check("fwd_drained", bus.out_valid, 0);

        // Skid: three back-to-back requests with downstream stalled
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.exec_src = SRC_ZI;
        bus.imm_val = 32'd1;
        step();
        check("skid_rdy_after1", bus.in_ready, 1);
        bus.imm_val = 32'd2;
        step();
        check("skid_rdy_after2", bus.in_ready, 0);
        check("skid_head1", bus.src_b, 32'd1);
        bus.imm_val = 32'd3;
        step();
        check("skid_held_rdy", bus.in_ready, 0);
        check("skid_held_head", bus.src_b, 32'd1);
        bus.out_ready = 1'b1;
        step();
        check("skid_seq2", bus.src_b, 32'd2);
        check("skid_rdy_back", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        check("skid_seq3", bus.src_b, 32'd3);
        check("skid_seq3_valid", bus.out_valid, 1);
        step();
        check("skid_drained", bus.out_valid, 0);

        // AMO memory datum bypass then hold
        bus.in_valid = 1'b1; bus.exec_src = SRC_MR;
        bus.rs_b_addr = 5'd3; bus.reg_b_value = 32'd7;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h1234; bus.reg_b_value = 32'd9;
        check("mr_bypass_a", bus.src_a, 32'hDEAD);
        check("mr_b", bus.src_b, 32'd7);
        step();
        bus.in_valid = 1'b0;
        check("mr_hold_a", bus.src_a, 32'hDEAD);
        check("mr_hold_b", bus.src_b, 32'd9);
        step();

        // Flush from TWO with a pending request
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.exec_src = SRC_ZI;
        bus.imm_val = 32'h55;
        step();
        bus.imm_val = 32'h66;
        step();
        check("fl_two_rdy", bus.in_ready, 0);
        flush = 1'b1; bus.imm_val = 32'h77;
        step();
        flush = 1'b0; bus.in_valid = 1'b0;
        check("fl_out_valid", bus.out_valid, 0);
        check("fl_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        step();
        check("fl_no_stale", bus.out_valid, 0);

        // Flush from ONE discards a same-cycle accept
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.imm_val = 32'h88;
        step();
        flush = 1'b1; bus.imm_val = 32'h99;
        step();
        flush = 1'b0; bus.in_valid = 1'b0;
        check("fl_acc_dropped", bus.out_valid, 0);
        step();
        check("fl_acc_stays", bus.out_valid, 0);

        // Undefined encoding then a legal one
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        bus.exec_src = exec_src_e'(3'd7); bus.imm_val = 32'h5A;
        bus.rs_a_addr = 5'd2; bus.reg_a_value = 32'h42;
        step();
        check("ill_flag", bus.illegal_src, 1);
        check("ill_valid", bus.out_valid, 1);
        check("ill_src_a", bus.src_a, 0);
        check("ill_src_b", bus.src_b, 0);
        bus.exec_src = SRC_RI; bus.imm_val = 32'h10;
        step();
        bus.in_valid = 1'b0;
        check("legal_flag", bus.illegal_src, 0);
        check("ri_src_a", bus.src_a, 32'h42);
        check("ri_src_b", bus.src_b, 32'h10);
        step();

        // CSR sources
        bus.in_valid = 1'b1; bus.exec_src = SRC_CA;
        bus.csr_rdata = 32'hC5C5; bus.reg_a_value = 32'h3;
        step();
        check("ca_src_a", bus.src_a, 32'hC5C5);
        check("ca_src_b", bus.src_b, 32'h3);
        bus.exec_src = SRC_CI; bus.imm_val = 32'h77;
        step();
        bus.in_valid = 1'b0;
        check("ci_src_b", bus.src_b, 32'h77);
        step();

        // Async reset mid-transfer
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.exec_src = SRC_ZI;
        bus.imm_val = 32'hA;
        step();
        bus.imm_val = 32'hB;
        step();
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_rdy", bus.in_ready, 1);
        check("mid_rst_src_b", bus.src_b, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("post_rst_empty", bus.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
